// File: rtl/as_imem_loader_if.sv
// as_imem_loader_if: byte-stream input and instruction-memory write side of the boot loader
interface as_imem_loader_if #(
  parameter int IMEM_ADDR_W = 10,
  parameter int INSTR_W = 32
);
  logic load_i;
  logic [7:0] rx_data_i;
  logic rx_valid_i;
  logic [IMEM_ADDR_W-1:0] imem_addr_o;
  logic [INSTR_W-1:0] imem_data_o;
  logic imem_wr_o;
  logic cpu_rst_o;
  logic busy_o;
  logic done_o;
  logic err_o;
  modport master (
    output load_i, rx_data_i, rx_valid_i,
    input imem_addr_o, imem_data_o, imem_wr_o, cpu_rst_o, busy_o, done_o, err_o
  );
  modport slave (
    input load_i, rx_data_i, rx_valid_i,
    output imem_addr_o, imem_data_o, imem_wr_o, cpu_rst_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/as_imem_loader.sv
// as_imem_loader: loads a length-prefixed little-endian byte stream into instruction memory while holding the core in reset
module as_imem_loader #(
  parameter int IMEM_ADDR_W = 10,
  parameter int INSTR_W = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int TIMEOUT = 100000
) (
  input logic clk_i,
  input logic rst_i,
  as_imem_loader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR} state_t;
  state_t state, nxt;
  logic [15:0] cnt, wcnt, full;
  logic [1:0] bcnt;
  logic [23:0] word;
  logic [TW-1:0] tmo;
  logic loading, start, expire, last, take;
  assign loading = state inside {CNT_LO, CNT_HI, DATA};
  assign start = bus.load_i && !loading;
  assign expire = loading && !bus.rx_valid_i && tmo == TW'(TIMEOUT - 1);
  assign full = {bus.rx_data_i, cnt[7:0]};
  assign last = wcnt == cnt - 16'd1;
  // a byte arriving in the final strobe cycle is past the image and is dropped
  assign take = state == DATA && bus.rx_valid_i && !(bus.imem_wr_o && last);
  // next-state decision; status outputs are registered from it
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = bus.load_i ? CNT_LO : state;
      CNT_LO: nxt = expire ? ERR : bus.rx_valid_i ? CNT_HI : CNT_LO;
      CNT_HI: nxt = expire ? ERR : !bus.rx_valid_i ? CNT_HI : full == 16'd0 ? DONE :
                    full > 16'(IMEM_DEPTH) ? ERR : DATA;
      DATA: nxt = (bus.imem_wr_o && last) ? DONE : expire ? ERR : DATA;
      default: nxt = IDLE;
    endcase
  end
  // loader FSM, byte assembly and registered memory-write port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      bcnt <= '0;
      word <= '0;
      tmo <= '0;
      bus.imem_addr_o <= '0;
      bus.imem_data_o <= '0;
      bus.imem_wr_o <= 1'b0;
      bus.cpu_rst_o <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.err_o <= 1'b0;
    end else begin
      state <= nxt;
      bus.busy_o <= nxt inside {CNT_LO, CNT_HI, DATA};
      bus.cpu_rst_o <= nxt inside {CNT_LO, CNT_HI, DATA, ERR};
      bus.done_o <= nxt == DONE;
      bus.err_o <= nxt == ERR;
      bus.imem_wr_o <= 1'b0;
      if (start) begin
        wcnt <= '0;
        bcnt <= '0;
        tmo <= '0;
        bus.imem_addr_o <= '0;
      end else if (loading) begin
        tmo <= bus.rx_valid_i ? '0 : tmo + 1'b1;
      end
      if (state == CNT_LO && bus.rx_valid_i) cnt[7:0] <= bus.rx_data_i;
      if (state == CNT_HI && bus.rx_valid_i) cnt[15:8] <= bus.rx_data_i;
      if (state == DATA && bus.imem_wr_o) begin
        bus.imem_addr_o <= bus.imem_addr_o + IMEM_ADDR_W'(4);
        wcnt <= wcnt + 16'd1;
      end
      if (take) begin
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          bus.imem_data_o <= INSTR_W'({bus.rx_data_i, word});
          bus.imem_wr_o <= 1'b1;
        end else begin
          word[{bcnt, 3'b000} +: 8] <= bus.rx_data_i;
        end
      end
    end
  end
endmodule

// File: doc/as_imem_loader.md
Name: as_imem_loader

Overview:
- Boot loader that sits directly upstream of the instruction memory write port.
- Receives a byte stream (UART receiver or debug bridge), assembles 32-bit little-endian instruction words and writes them sequentially into the instruction memory from byte address 0.
- Holds the core in reset while loading.
- Lets the design be reprogrammed at runtime without resynthesising the memory init file.

Parameters:
- IMEM_ADDR_W, 10, instruction memory byte-address width; word index is addr[IMEM_ADDR_W-1:2].
- INSTR_W, 32, instruction width; fixed at 32 (4 bytes per word).
- IMEM_DEPTH, 256, memory capacity in words.
- TIMEOUT, 100000, maximum idle clocks between bytes during a load before aborting.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- load_i  in  1  single-cycle start-load request.
- rx_data_i  in  8  incoming byte.
- rx_valid_i  in  1  rx_data_i valid this cycle; one byte per asserted cycle, no backpressure.
- imem_addr_o  out  IMEM_ADDR_W  byte address to the instruction memory, word aligned (bits [1:0] = 0).
- imem_data_o  out  INSTR_W  assembled instruction word.
- imem_wr_o  out  1  one-cycle write strobe to the instruction memory.
- cpu_rst_o  out  1  holds the core in reset while loading or after an error.
- busy_o  out  1  load in progress.
- done_o  out  1  last load completed successfully; level signal.
- err_o  out  1  last load aborted; level signal.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
  - cpu_rst_o = 0 so the core runs the preloaded image.
- States: IDLE, CNT_LO, CNT_HI, DATA, DONE, ERR.
- IDLE/DONE/ERR + load_i=1:
  - Go to CNT_LO.
  - busy_o=1, cpu_rst_o=1, done_o=0, err_o=0.
  - Byte counter, word counter, address and timeout counter cleared.
- load_i while busy_o=1 is ignored.
- Bytes in IDLE/DONE/ERR are discarded.
- CNT_LO: accepted byte becomes count[7:0]; go to CNT_HI.
- CNT_HI: accepted byte becomes count[15:8]; on that byte:
  - count == 0 → DONE.
  - count > IMEM_DEPTH → ERR.
  - Otherwise → DATA.
- DATA:
  - Byte k of each word goes to word[8k+7:8k], little-endian; the first byte is the LSB.
  - On the 4th byte, the next cycle drives:
    - imem_data_o = assembled word
    - imem_addr_o = current word address
    - imem_wr_o = 1 for exactly one cycle
  - The cycle after the strobe, imem_addr_o increments by 4.
  - DATA keeps accepting bytes in the strobe cycle; a byte arriving then is the 1st byte of the next word and must not be lost.
  - After writing word number count: go to DONE in the cycle after the final strobe.
- Address wrap: not possible, because count ≤ IMEM_DEPTH; the last address is 4*(IMEM_DEPTH-1).
- Timeout:
  - Applies in CNT_LO, CNT_HI and DATA.
  - The counter restarts on each accepted byte.
  - Reaching TIMEOUT idle cycles → ERR.
  - No write of a partial word.
- DONE: busy_o=0, cpu_rst_o=0, done_o=1; held until the next load_i.
- ERR: busy_o=0, cpu_rst_o=1, err_o=1; held until the next load_i or reset.
  - The core stays in reset on a corrupted image.
- imem_data_o and imem_addr_o are registered and hold their last value when imem_wr_o=0.
- Reset mid-load: asynchronous return to IDLE with all outputs 0.
  - Memory contents already written are not restored.
  - No write strobe is emitted after rst_i rises.

Test Plan:
- Reset then idle → all outputs 0; rx bytes 0x13,0x00 with no load_i → no imem_wr_o.
- load_i, bytes 02 00 | 13 01 50 00 | 93 01 C0 00 → two strobes:
  - addr 0x000, data 0x00500113
  - addr 0x004, data 0x00C00193
  - then done_o=1, cpu_rst_o=0, busy_o=0.
- Back-to-back bytes, rx_valid_i continuously high, count=3 → three strobes on cycles 4 apart, no byte lost, addresses 0x0/0x4/0x8.
- Counts 0x0000 → done_o=1 with no strobe; count 0x0101 (257 > 256) → err_o=1, cpu_rst_o=1, no strobe.
- count=1, send 2 data bytes then stall TIMEOUT cycles → err_o=1, no write; a new load_i then clears err_o and completes normally.
- Assert rst_i between bytes 2 and 3 of a word → immediate IDLE, outputs 0, no strobe; load_i pulse during busy_o=1 → ignored, load completes unchanged.
